// File: rtl/eth_mac_swap_64.sv
// eth_mac_swap_64: Ethernet reply engine for a 64-bit datapath.
// Takes a received header + payload (from eth_axis_rx_64) and produces a reply
// whose destination is the received source and whose source is the local
// station address. The payload is copied unchanged. Frames that are not for
// this station (unicast mismatch, not broadcast) are consumed and dropped when
// FILTER_ENABLE is set.
//
// Handshake rule for every valid/ready pair on this block: a transfer happens
// on a rising clk edge where valid && ready are both 1; a producer holds valid
// and its data stable until that edge, and ready may change freely.
module eth_mac_swap_64 #(
  parameter bit FILTER_ENABLE = 1'b1,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,

  // received header
  input  logic                   input_eth_hdr_valid,
  output logic                   input_eth_hdr_ready,
  input  logic [47:0]            input_eth_dest_mac,
  input  logic [47:0]            input_eth_src_mac,
  input  logic [15:0]            input_eth_type,

  // received payload
  input  logic [63:0]            input_eth_payload_tdata,
  input  logic [7:0]             input_eth_payload_tkeep,
  input  logic                   input_eth_payload_tvalid,
  output logic                   input_eth_payload_tready,
  input  logic                   input_eth_payload_tlast,
  input  logic                   input_eth_payload_tuser,

  // reply header
  output logic                   output_eth_hdr_valid,
  input  logic                   output_eth_hdr_ready,
  output logic [47:0]            output_eth_dest_mac,
  output logic [47:0]            output_eth_src_mac,
  output logic [15:0]            output_eth_type,

  // reply payload
  output logic [63:0]            output_eth_payload_tdata,
  output logic [7:0]             output_eth_payload_tkeep,
  output logic                   output_eth_payload_tvalid,
  input  logic                   output_eth_payload_tready,
  output logic                   output_eth_payload_tlast,
  output logic                   output_eth_payload_tuser,

  // configuration and status
  input  logic [47:0]            local_mac,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output logic [COUNT_WIDTH-1:0] drop_count,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  state_t                 state_q, state_d;

  logic                   hdr_valid_q, hdr_valid_d;
  logic [47:0]            hdr_dest_q, hdr_dest_d;
  logic [47:0]            hdr_src_q, hdr_src_d;
  logic [15:0]            hdr_type_q, hdr_type_d;

  logic                   out_valid_q, out_valid_d;
  logic [63:0]            out_data_q, out_data_d;
  logic [7:0]             out_keep_q, out_keep_d;
  logic                   out_last_q, out_last_d;
  logic                   out_user_q, out_user_d;

  logic                   skid_valid_q, skid_valid_d;
  logic [63:0]            skid_data_q, skid_data_d;
  logic [7:0]             skid_keep_q, skid_keep_d;
  logic                   skid_last_q, skid_last_d;
  logic                   skid_user_q, skid_user_d;

  logic                   in_tready_q, in_tready_d;
  logic [COUNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic [COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic                   hdr_xfer;
  logic                   addr_match;
  logic                   in_xfer;
  logic                   last_xfer;
  logic                   fwd_xfer;
  logic                   out_can_load;

  // Header ready is combinational so a header can be taken the very first
  // edge after reset release, and in the cycle after a frame's last beat.
  // It is qualified by rst so it reads 0 while reset is held.
  assign input_eth_hdr_ready = rst && (state_q == ST_IDLE) &&
                               (!hdr_valid_q || output_eth_hdr_ready);

  assign input_eth_payload_tready  = in_tready_q;

  assign output_eth_hdr_valid      = hdr_valid_q;
  assign output_eth_dest_mac       = hdr_dest_q;
  assign output_eth_src_mac        = hdr_src_q;
  assign output_eth_type           = hdr_type_q;

  assign output_eth_payload_tdata  = out_data_q;
  assign output_eth_payload_tkeep  = out_keep_q;
  assign output_eth_payload_tvalid = out_valid_q;
  assign output_eth_payload_tlast  = out_last_q;
  assign output_eth_payload_tuser  = out_user_q;

  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign busy        = (state_q != ST_IDLE);
  assign state_dbg   = state_q;

  // Next-state logic: frame FSM, reply header register, payload output
  // register with one-entry skid buffer, registered payload ready, counters.
  always_comb begin
    state_d       = state_q;
    hdr_valid_d   = hdr_valid_q;
    hdr_dest_d    = hdr_dest_q;
    hdr_src_d     = hdr_src_q;
    hdr_type_d    = hdr_type_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_keep_d    = out_keep_q;
    out_last_d    = out_last_q;
    out_user_d    = out_user_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_keep_d   = skid_keep_q;
    skid_last_d   = skid_last_q;
    skid_user_d   = skid_user_q;
    in_tready_d   = 1'b0;
    frame_count_d = frame_count_q;
    drop_count_d  = drop_count_q;

    hdr_xfer   = input_eth_hdr_valid && input_eth_hdr_ready;
    addr_match = (FILTER_ENABLE == 1'b0) ||
                 (input_eth_dest_mac == local_mac) ||
                 (input_eth_dest_mac == BCAST_MAC);
    in_xfer    = input_eth_payload_tvalid && in_tready_q;
    last_xfer  = in_xfer && input_eth_payload_tlast;
    fwd_xfer   = in_xfer && (state_q == ST_FORWARD);

    // The header register drains on its own handshake, independent of payload.
    if (output_eth_hdr_ready) begin
      hdr_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (hdr_xfer) begin
          if (addr_match) begin
            hdr_valid_d = 1'b1;
            hdr_dest_d  = input_eth_src_mac;
            hdr_src_d   = local_mac;
            hdr_type_d  = input_eth_type;
            state_d     = ST_FORWARD;
          end else begin
            state_d     = ST_DROP;
          end
        end
      end
      ST_FORWARD: begin
        if (last_xfer) begin
          frame_count_d = frame_count_q + COUNT_WIDTH'(1);
          state_d       = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (last_xfer) begin
          drop_count_d = drop_count_q + COUNT_WIDTH'(1);
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Payload path. While forwarding, in_tready_q == !skid_valid_q, so an
    // accepted beat always finds the skid empty. The skid drains into the
    // output register in any state, so a previous frame's tail keeps flowing
    // while the next header is handled.
    out_can_load = !out_valid_q || output_eth_payload_tready;
    if (out_can_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_keep_d   = skid_keep_q;
        out_last_d   = skid_last_q;
        out_user_d   = skid_user_q;
        skid_valid_d = 1'b0;
      end else if (fwd_xfer) begin
        out_valid_d  = 1'b1;
        out_data_d   = input_eth_payload_tdata;
        out_keep_d   = input_eth_payload_tkeep;
        out_last_d   = input_eth_payload_tlast;
        out_user_d   = input_eth_payload_tuser;
      end else begin
        out_valid_d  = 1'b0;
      end
    end else if (fwd_xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = input_eth_payload_tdata;
      skid_keep_d  = input_eth_payload_tkeep;
      skid_last_d  = input_eth_payload_tlast;
      skid_user_d  = input_eth_payload_tuser;
    end

    // Payload ready for the next cycle follows the state being entered.
    case (state_d)
      ST_FORWARD: in_tready_d = !skid_valid_d;
      ST_DROP:    in_tready_d = 1'b1;
      default:    in_tready_d = 1'b0;
    endcase
  end

  // State and datapath registers; everything clears on reset so no stale
  // beat or header appears after a mid-frame reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      hdr_valid_q   <= 1'b0;
      hdr_dest_q    <= '0;
      hdr_src_q     <= '0;
      hdr_type_q    <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_keep_q    <= '0;
      out_last_q    <= 1'b0;
      out_user_q    <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_keep_q   <= '0;
      skid_last_q   <= 1'b0;
      skid_user_q   <= 1'b0;
      in_tready_q   <= 1'b0;
      frame_count_q <= '0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      hdr_valid_q   <= hdr_valid_d;
      hdr_dest_q    <= hdr_dest_d;
      hdr_src_q     <= hdr_src_d;
      hdr_type_q    <= hdr_type_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_keep_q    <= out_keep_d;
      out_last_q    <= out_last_d;
      out_user_q    <= out_user_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_keep_q   <= skid_keep_d;
      skid_last_q   <= skid_last_d;
      skid_user_q   <= skid_user_d;
      in_tready_q   <= in_tready_d;
      frame_count_q <= frame_count_d;
      drop_count_q  <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_eth_mac_swap_64.sv
// Testbench for eth_mac_swap_64: directed frames with hand-computed replies.
module tb_eth_mac_swap_64;

  typedef logic [73:0]  beat_t;   // {tdata, tkeep, tlast, tuser}
  typedef logic [111:0] hdr_t;    // {dest, src, type}

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;

  // ---------------- main DUT (filtering on) ----------------
  logic        in_hdr_valid = 1'b0, in_hdr_ready;
  logic [47:0] in_dest = '0, in_src = '0;
  logic [15:0] in_type = '0;
  logic [63:0] in_tdata = '0;
  logic [7:0]  in_tkeep = '0;
  logic        in_tvalid = 1'b0, in_tready, in_tlast = 1'b0, in_tuser = 1'b0;
  logic        out_hdr_valid, out_hdr_ready = 1'b1;
  logic [47:0] out_dest, out_src;
  logic [15:0] out_type;
  logic [63:0] out_tdata;
  logic [7:0]  out_tkeep;
  logic        out_tvalid, out_tready = 1'b1, out_tlast, out_tuser;
  logic [47:0] local_mac = LOCAL;
  logic [31:0] frame_count, drop_count;
  logic        busy;
  logic [1:0]  state_dbg;

  eth_mac_swap_64 #(.FILTER_ENABLE(1'b1), .COUNT_WIDTH(32)) u_dut (
    .clk(clk), .rst(rst),
    .input_eth_hdr_valid(in_hdr_valid), .input_eth_hdr_ready(in_hdr_ready),
    .input_eth_dest_mac(in_dest), .input_eth_src_mac(in_src), .input_eth_type(in_type),
    .input_eth_payload_tdata(in_tdata), .input_eth_payload_tkeep(in_tkeep),
    .input_eth_payload_tvalid(in_tvalid), .input_eth_payload_tready(in_tready),
    .input_eth_payload_tlast(in_tlast), .input_eth_payload_tuser(in_tuser),
    .output_eth_hdr_valid(out_hdr_valid), .output_eth_hdr_ready(out_hdr_ready),
    .output_eth_dest_mac(out_dest), .output_eth_src_mac(out_src), .output_eth_type(out_type),
    .output_eth_payload_tdata(out_tdata), .output_eth_payload_tkeep(out_tkeep),
    .output_eth_payload_tvalid(out_tvalid), .output_eth_payload_tready(out_tready),
    .output_eth_payload_tlast(out_tlast), .output_eth_payload_tuser(out_tuser),
    .local_mac(local_mac), .frame_count(frame_count), .drop_count(drop_count),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- second DUT (no filter, 2-bit counters) ----------------
  logic        nf_hdr_valid = 1'b0, nf_hdr_ready;
  logic [47:0] nf_dest = '0, nf_src = '0;
  logic [63:0] nf_tdata = '0;
  logic        nf_tvalid = 1'b0, nf_tready;
  logic        nf_out_hdr_valid;
  logic [47:0] nf_out_dest, nf_out_src;
  logic [15:0] nf_out_type;
  logic [63:0] nf_out_tdata;
  logic [7:0]  nf_out_tkeep;
  logic        nf_out_tvalid, nf_out_tlast, nf_out_tuser;
  logic [1:0]  nf_frame_count, nf_drop_count;
  logic        nf_busy;
  logic [1:0]  nf_state_dbg;

  eth_mac_swap_64 #(.FILTER_ENABLE(1'b0), .COUNT_WIDTH(2)) u_nf (
    .clk(clk), .rst(rst),
    .input_eth_hdr_valid(nf_hdr_valid), .input_eth_hdr_ready(nf_hdr_ready),
    .input_eth_dest_mac(nf_dest), .input_eth_src_mac(nf_src), .input_eth_type(16'h0800),
    .input_eth_payload_tdata(nf_tdata), .input_eth_payload_tkeep(8'hFF),
    .input_eth_payload_tvalid(nf_tvalid), .input_eth_payload_tready(nf_tready),
    .input_eth_payload_tlast(1'b1), .input_eth_payload_tuser(1'b0),
    .output_eth_hdr_valid(nf_out_hdr_valid), .output_eth_hdr_ready(1'b1),
    .output_eth_dest_mac(nf_out_dest), .output_eth_src_mac(nf_out_src),
    .output_eth_type(nf_out_type),
    .output_eth_payload_tdata(nf_out_tdata), .output_eth_payload_tkeep(nf_out_tkeep),
    .output_eth_payload_tvalid(nf_out_tvalid), .output_eth_payload_tready(1'b1),
    .output_eth_payload_tlast(nf_out_tlast), .output_eth_payload_tuser(nf_out_tuser),
    .local_mac(LOCAL), .frame_count(nf_frame_count), .drop_count(nf_drop_count),
    .busy(nf_busy), .state_dbg(nf_state_dbg)
  );

  // ---------------- output ready drivers ----------------
  logic rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    out_tready    = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    out_hdr_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitors (sampled at negedge) ----------------
  beat_t out_beat;
  hdr_t  out_hdr;
  assign out_beat = {out_tdata, out_tkeep, out_tlast, out_tuser};
  assign out_hdr  = {out_dest, out_src, out_type};

  beat_t got_q[$];
  int    got_cyc[$];
  hdr_t  hdr_got_q[$];
  int    stab_viol = 0;
  logic  pv = 1'b0, pr = 1'b0, hv = 1'b0, hr = 1'b0;
  beat_t pd;
  hdr_t  hd;

  always @(negedge clk) begin
    if (!rst) begin
      pv = 1'b0;
      hv = 1'b0;
    end else begin
      if (pv && !pr && (!out_tvalid || out_beat !== pd)) stab_viol++;
      if (hv && !hr && (!out_hdr_valid || out_hdr !== hd)) stab_viol++;
      if (out_tvalid && out_tready) begin
        got_q.push_back(out_beat);
        got_cyc.push_back(cyc);
      end
      if (out_hdr_valid && out_hdr_ready) hdr_got_q.push_back(out_hdr);
      pv = out_tvalid; pr = out_tready; pd = out_beat;
      hv = out_hdr_valid; hr = out_hdr_ready; hd = out_hdr;
    end
  end

  int          nf_hdr_cnt = 0, nf_beat_cnt = 0;
  logic [47:0] nf_last_dest = '0;
  always @(negedge clk) begin
    if (rst && nf_out_hdr_valid) begin
      nf_hdr_cnt++;
      nf_last_dest = nf_out_dest;
    end
    if (rst && nf_out_tvalid) nf_beat_cnt++;
  end

  // ---------------- scoreboard ----------------
  beat_t exp_q[$];
  int    acc_cyc[$];
  int    stalls;

  task automatic clear_sb();
    got_q.delete(); got_cyc.delete(); hdr_got_q.delete();
    exp_q.delete(); acc_cyc.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    bit ok = 0;
    in_dest = d; in_src = s; in_type = t; in_hdr_valid = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (in_hdr_ready) ok = 1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      checks++; failures++;
      $display("FAIL hdr_accept_timeout: got no ready expected ready within 2000 cycles");
    end
    in_hdr_valid = 1'b0;
  endtask

  task automatic send_beats(input int n, input logic [63:0] base, input logic [7:0] last_keep,
                            input logic last_user, input logic end_frame, input logic fwd);
    stalls = 0;
    for (int b = 0; b < n; b++) begin
      bit ok = 0;
      in_tdata  = base + 64'(b);
      in_tkeep  = (b == n - 1) ? last_keep : 8'hFF;
      in_tlast  = end_frame && (b == n - 1);
      in_tuser  = (b == n - 1) ? last_user : 1'b0;
      in_tvalid = 1'b1;
      for (int i = 0; i < 2000 && !ok; i++) begin
        @(negedge clk);
        if (in_tready) ok = 1;
        else stalls++;
      end
      if (!ok) begin
        checks++; failures++;
        $display("FAIL beat_accept_timeout: got no tready expected tready within 2000 cycles");
        in_tvalid = 1'b0;
        return;
      end
      if (fwd) exp_q.push_back({in_tdata, in_tkeep, in_tlast, in_tuser});
      acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
    end
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int n_beats, input int n_hdrs);
    bit ok = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      if (got_q.size() >= n_beats && hdr_got_q.size() >= n_hdrs) ok = 1;
      else @(posedge clk);
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout: got %0d beats %0d hdrs expected %0d beats %0d hdrs",
               got_q.size(), hdr_got_q.size(), n_beats, n_hdrs);
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_hdr_ready !== 1'b0) begin failures++; $display("FAIL rst_hdr_ready: got %b expected 0", in_hdr_ready); end
    checks++; if (in_tready !== 1'b0) begin failures++; $display("FAIL rst_tready: got %b expected 0", in_tready); end
    checks++; if (out_hdr_valid !== 1'b0) begin failures++; $display("FAIL rst_hdr_valid: got %b expected 0", out_hdr_valid); end
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid: got %b expected 0", out_tvalid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (frame_count !== 32'd0) begin failures++; $display("FAIL rst_frame_count: got %0d expected 0", frame_count); end
    checks++; if (drop_count !== 32'd0) begin failures++; $display("FAIL rst_drop_count: got %0d expected 0", drop_count); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (in_hdr_ready !== 1'b1) begin failures++; $display("FAIL post_rst_hdr_ready: got %b expected 1", in_hdr_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_forward();
    clear_sb();
    send_hdr(LOCAL, 48'h5A_51_52_53_54_55, 16'h0800);
    checks++; if (out_hdr_valid !== 1'b1) begin failures++; $display("FAIL fwd_hdr_latency: got %b expected 1", out_hdr_valid); end
    checks++; if (state_dbg !== 2'd1) begin failures++; $display("FAIL fwd_state: got %0d expected 1", state_dbg); end
    send_beats(3, 64'h1111_2222_3333_0000, 8'h0F, 1'b0, 1'b1, 1'b1);
    checks++; if (stalls !== 0) begin failures++; $display("FAIL fwd_throughput: got %0d stalls expected 0", stalls); end
    wait_drain(3, 1);
    checks++; if (hdr_got_q.size() !== 1) begin failures++; $display("FAIL fwd_hdr_count: got %0d expected 1", hdr_got_q.size()); end
    if (hdr_got_q.size() > 0) begin
      checks++;
      if (hdr_got_q[0] !== {48'h5A_51_52_53_54_55, LOCAL, 16'h0800}) begin
        failures++; $display("FAIL fwd_hdr_fields: got %h expected %h", hdr_got_q[0], {48'h5A_51_52_53_54_55, LOCAL, 16'h0800});
      end
    end
    checks++; if (got_q.size() !== 3) begin failures++; $display("FAIL fwd_beat_count: got %0d expected 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fwd_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    if (got_q.size() > 2) begin
      checks++; if (got_q[2][9:2] !== 8'h0F || got_q[2][1] !== 1'b1) begin failures++; $display("FAIL fwd_last_keep: got %h expected keep 0f last 1", got_q[2][9:1]); end
      checks++; if (got_cyc[0] - acc_cyc[0] !== 1) begin failures++; $display("FAIL fwd_beat_latency: got %0d expected 1", got_cyc[0] - acc_cyc[0]); end
    end
    checks++; if (frame_count !== 32'd1) begin failures++; $display("FAIL fwd_frame_count: got %0d expected 1", frame_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fwd_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_drop();
    clear_sb();
    send_hdr(48'h02_00_00_00_00_99, 48'h5A_51_52_53_54_55, 16'h0800);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drop_busy: got %b expected 1", busy); end
    checks++; if (state_dbg !== 2'd2) begin failures++; $display("FAIL drop_state: got %0d expected 2", state_dbg); end
    send_beats(5, 64'hDEAD_0000_0000_0000, 8'h3F, 1'b0, 1'b1, 1'b0);
    checks++; if (stalls !== 0) begin failures++; $display("FAIL drop_back_to_back: got %0d stalls expected 0", stalls); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (hdr_got_q.size() !== 0) begin failures++; $display("FAIL drop_no_hdr: got %0d expected 0", hdr_got_q.size()); end
    checks++; if (got_q.size() !== 0) begin failures++; $display("FAIL drop_no_beats: got %0d expected 0", got_q.size()); end
    checks++; if (drop_count !== 32'd1) begin failures++; $display("FAIL drop_count: got %0d expected 1", drop_count); end
    checks++; if (frame_count !== 32'd1) begin failures++; $display("FAIL drop_frame_count: got %0d expected 1", frame_count); end
  endtask

  task automatic test_broadcast();
    clear_sb();
    send_hdr(48'hFF_FF_FF_FF_FF_FF, 48'h0A_0B_0C_0D_0E_0F, 16'h86DD);
    send_beats(2, 64'hB0B0_0000_0000_0000, 8'h01, 1'b1, 1'b1, 1'b1);
    wait_drain(2, 1);
    if (hdr_got_q.size() > 0) begin
      checks++;
      if (hdr_got_q[0] !== {48'h0A_0B_0C_0D_0E_0F, LOCAL, 16'h86DD}) begin
        failures++; $display("FAIL bcast_hdr: got %h expected %h", hdr_got_q[0], {48'h0A_0B_0C_0D_0E_0F, LOCAL, 16'h86DD});
      end
    end
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL bcast_beat_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bcast_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (frame_count !== 32'd2) begin failures++; $display("FAIL bcast_frame_count: got %0d expected 2", frame_count); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    clear_sb();
    rand_ready = 1'b1;
    for (int f = 0; f < 100; f++) begin
      send_hdr(LOCAL, {32'hC0DE_0000, 16'(f)}, 16'h0800);
      send_beats(8, {16'(f), 48'h0}, f[0] ? 8'h0F : 8'hFF, (f % 3) == 0, 1'b1, 1'b1);
    end
    wait_drain(800, 100);
    rand_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (got_q.size() !== 800) begin failures++; $display("FAIL b2b_beat_count: got %0d expected 800", got_q.size()); end
    checks++; if (exp_q.size() !== 800) begin failures++; $display("FAIL b2b_sent_count: got %0d expected 800", exp_q.size()); end
    for (int i = 0; i < 800 && i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (bad <= 10) $display("FAIL b2b_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL b2b_beats_in_order: got %0d bad beats expected 0", bad); end
    checks++; if (hdr_got_q.size() !== 100) begin failures++; $display("FAIL b2b_hdr_count: got %0d expected 100", hdr_got_q.size()); end
    if (hdr_got_q.size() == 100) begin
      checks++;
      if (hdr_got_q[99] !== {48'hC0DE_0000_0063, LOCAL, 16'h0800}) begin
        failures++; $display("FAIL b2b_last_hdr: got %h expected %h", hdr_got_q[99], {48'hC0DE_0000_0063, LOCAL, 16'h0800});
      end
    end
    checks++; if (stab_viol !== 0) begin failures++; $display("FAIL b2b_stability: got %0d violations expected 0", stab_viol); end
    checks++; if (frame_count !== 32'd102) begin failures++; $display("FAIL b2b_frame_count: got %0d expected 102", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    clear_sb();
    send_hdr(LOCAL, 48'h11_22_33_44_55_66, 16'h0806);
    send_beats(2, 64'hAAAA_0000_0000_0000, 8'hFF, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (out_hdr_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_hdr_valid: got %b expected 0", out_hdr_valid); end
    checks++; if (out_tvalid !== 1'b0) begin failures++; $display("FAIL mid_rst_tvalid: got %b expected 0", out_tvalid); end
    checks++; if (out_tdata !== 64'd0) begin failures++; $display("FAIL mid_rst_tdata: got %h expected 0", out_tdata); end
    checks++; if (in_tready !== 1'b0) begin failures++; $display("FAIL mid_rst_tready: got %b expected 0", in_tready); end
    checks++; if (in_hdr_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_hdr_ready: got %b expected 0", in_hdr_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    checks++; if (frame_count !== 32'd0) begin failures++; $display("FAIL mid_rst_frame_count: got %0d expected 0", frame_count); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clear_sb();
    send_hdr(LOCAL, 48'h77_66_55_44_33_22, 16'h0800);
    send_beats(2, 64'h5555_0000_0000_0000, 8'h03, 1'b0, 1'b1, 1'b1);
    wait_drain(2, 1);
    checks++; if (got_q.size() !== 2) begin failures++; $display("FAIL post_rst_beat_count: got %0d expected 2", got_q.size()); end
    for (int i = 0; i < 2 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL post_rst_beat%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (hdr_got_q.size() !== 1) begin failures++; $display("FAIL post_rst_hdr_count: got %0d expected 1", hdr_got_q.size()); end
    checks++; if (frame_count !== 32'd1) begin failures++; $display("FAIL post_rst_frame_count: got %0d expected 1", frame_count); end
  endtask

  task automatic test_no_filter_wrap();
    for (int f = 0; f < 5; f++) begin
      bit ok = 0;
      nf_dest = 48'h02_00_00_00_00_99;
      nf_src  = {40'h3C_3C_3C_3C_3C, 8'(f)};
      nf_hdr_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(negedge clk);
        if (nf_hdr_ready) ok = 1;
      end
      @(posedge clk);
      #1;
      nf_hdr_valid = 1'b0;
      nf_tdata  = 64'(f);
      nf_tvalid = 1'b1;
      for (int i = 0; i < 200 && ok; i++) begin
        @(negedge clk);
        if (nf_tready) break;
        if (i == 199) ok = 0;
      end
      @(posedge clk);
      #1;
      nf_tvalid = 1'b0;
      if (!ok) begin
        checks++; failures++;
        $display("FAIL nf_handshake_timeout: got no ready expected ready for frame %0d", f);
      end
    end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (nf_hdr_cnt !== 5) begin failures++; $display("FAIL nf_hdr_count: got %0d expected 5", nf_hdr_cnt); end
    checks++; if (nf_beat_cnt !== 5) begin failures++; $display("FAIL nf_beat_count: got %0d expected 5", nf_beat_cnt); end
    checks++; if (nf_last_dest !== 48'h3C_3C_3C_3C_3C_04) begin failures++; $display("FAIL nf_last_dest: got %h expected 3c3c3c3c3c04", nf_last_dest); end
    checks++; if (nf_frame_count !== 2'd1) begin failures++; $display("FAIL nf_frame_count_wrap: got %0d expected 1", nf_frame_count); end
    checks++; if (nf_drop_count !== 2'd0) begin failures++; $display("FAIL nf_drop_count: got %0d expected 0", nf_drop_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_forward();
    test_drop();
    test_broadcast();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_filter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected completion within 90000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eth_mac_swap_64.md
ETH_MAC_SWAP_64 -- requirements
Module: eth_mac_swap_64

Interface
REQ-001 SHALL have parameter FILTER_ENABLE, default 1: 1 = drop frames not addressed to local_mac or broadcast; 0 = reply to all frames.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32: width of the frame_count and drop_count outputs.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, as stated in REQ-004 and REQ-005.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 input_eth_hdr_valid/input_eth_hdr_ready  in/out  1/1  header handshake from eth_axis_rx_64.
REQ-007 input_eth_dest_mac, input_eth_src_mac, input_eth_type  in  48, 48, 16  received header fields.
REQ-008 input_eth_payload_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  64/8/1/1/1/1  received payload stream.
REQ-009 output_eth_hdr_valid/output_eth_hdr_ready  out/in  1/1  header handshake to eth_axis_tx_64.
REQ-010 output_eth_dest_mac, output_eth_src_mac, output_eth_type  out  48, 48, 16  reply header fields.
REQ-011 output_eth_payload_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  64/8/1/1/1/1  reply payload stream.
REQ-012 local_mac  in  48  station address; quasi-static.
REQ-013 frame_count, drop_count  out  COUNT_WIDTH each  count of forwarded frames and of dropped frames.
REQ-014 busy  out  1  high when the state machine is not in IDLE.

Function
REQ-015 SHALL implement states IDLE, FORWARD and DROP.
REQ-016 IDLE: input_eth_hdr_ready SHALL be 1 when the output header register is empty or being drained (!output_eth_hdr_valid || output_eth_hdr_ready); it SHALL be 0 in FORWARD and DROP.
REQ-017 Header accept in IDLE SHALL evaluate the frame as "match" when FILTER_ENABLE==0, or dest==local_mac, or dest==48'hFFFFFFFFFFFF.
REQ-018 On a match, the header register SHALL load dest=input src_mac, src=local_mac (sampled at accept) and type=input type.
REQ-019 On a match, output_eth_hdr_valid SHALL assert on the next cycle (latency 1) and the FSM SHALL go to FORWARD.
REQ-020 On a non-match, no output header SHALL be produced and the FSM SHALL go to DROP.
REQ-021 Payload tready SHALL be 0 in IDLE; no payload beat is accepted before its header.
REQ-022 FORWARD: payload SHALL pass through an output register plus a one-entry skid buffer.
REQ-023 FORWARD: input_eth_payload_tready SHALL be registered and equal !skid_valid.
REQ-024 FORWARD: tdata, tkeep, tlast and tuser SHALL be forwarded unmodified, with latency 1 cycle.
REQ-025 FORWARD: sustained throughput SHALL be 1 beat/cycle with output tready held high.
REQ-026 FORWARD: beats SHALL never be lost or duplicated under arbitrary output_eth_payload_tready stalls.
REQ-027 FORWARD: acceptance of the input beat with tlast SHALL increment frame_count (regardless of tuser) and return the FSM to IDLE; the skid/output registers drain independently.
REQ-028 DROP: input_eth_payload_tready SHALL be 1 and beats SHALL be discarded; acceptance of the tlast beat SHALL increment drop_count and return to IDLE.
REQ-029 The next header SHALL be acceptable in the cycle after the last beat is accepted, subject to REQ-016.
REQ-030 The header and payload output channels SHALL be independent; the payload SHALL NOT wait for the header handshake.
REQ-031 Counters SHALL wrap modulo 2^COUNT_WIDTH.
REQ-032 Output valids SHALL never deassert without the corresponding ready; data SHALL be stable while valid && !ready.

Reset
REQ-033 While rst==0: state=IDLE; all valids, input readies and busy=0; skid empty; frame_count=drop_count=0; data registers SHALL be don't-care.
REQ-034 Reset mid-frame SHALL abandon the frame with no partial output after release; upstream is reset by the same rst.
REQ-035 The first header SHALL be acceptable on the first clock edge after rst deasserts.

Verification
REQ-036 local_mac=02:00:00:00:00:01; header dest=02:00:00:00:00:01, src=5A:51:52:53:54:55, type=0x0800; 3-beat payload, last tkeep=0x0F -> output header dest=5A:51:52:53:54:55, src=02:00:00:00:00:01, type=0x0800; identical 3 beats; frame_count=1.
REQ-037 FILTER_ENABLE=1, dest=02:00:00:00:00:99; 5-beat frame -> no output header, no output beats; all beats accepted back-to-back; drop_count=1.
REQ-038 Broadcast dest FF:FF:FF:FF:FF:FF -> forwarded, frame_count increments; same unicast mismatch with FILTER_ENABLE=0 -> forwarded.
REQ-039 100 back-to-back 8-beat frames, output tready random 50% -> all 800 beats in order with matching tkeep/tlast/tuser; no valid drop while stalled; frame_count=100.
REQ-040 rst asserted at beat 2 of 6 -> all outputs 0 asynchronously; after release, a new 2-beat frame forwards correctly; frame_count=1.
